// File: rtl/des_ks_pkg.sv
// Shared DES key-schedule tables, rotation helpers and FSM state type.
// Used by the sequential key schedule and by the PC-2 wiring block.
package des_ks_pkg;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_GEN  = 1'b1
    } ks_state_e;

    // Entry i holds the left-shift amount for DES round i+1.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from 1 at the MSB, so table entry t selects vector bit (width - t).
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        logic [5:0]  src;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src = 6'(64 - PC1_TAB[i]);
            r[6'(55 - i)] = key[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src = 6'(56 - PC2_TAB[i]);
            r[6'(47 - i)] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/des_ks_pc2.sv
// Combinational PC-2 selection (56-bit C||D to 48-bit round key).
// Pure wiring, shared with the iterative round datapath.
module des_ks_pc2
    import des_ks_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] rk
);

    assign rk = pc2(cd);

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: one key in, 16 round keys out in forward or reverse order.
// Optional odd-parity key check is enabled by defining DES_KS_PARITY_CHK_EN (KEY_W == 64 only).
module des_key_schedule_seq
    import des_ks_pkg::*;
#(
    parameter int KEY_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic             decrypt,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [47:0]      rk_data,
    output logic [3:0]       rk_round,
    output logic             rk_last,
    output logic             busy,
    output logic             key_par_err
);

    ks_state_e   state;
    logic [55:0] cd;
    logic [3:0]  cnt;
    logic        mode;
    logic [63:0] key64;
    logic [55:0] cd_load;
    logic        key_par_ok;

    // A parity-stripped key gets zero parity slots so PC-1 sees standard numbering.
    generate
        if (KEY_W == 64) begin : g_key64
            assign key64 = key_in;
        end else if (KEY_W == 56) begin : g_key56
            for (genvar j = 0; j < 8; j++) begin : g_byte
                assign key64[63-8*j -: 7] = key_in[55-7*j -: 7];
                assign key64[56-8*j]      = 1'b0;
            end
        end else begin : g_bad_width
            $error("des_key_schedule_seq: KEY_W must be 64 or 56");
        end
    endgenerate

    assign cd_load = pc1(key64);

`ifdef DES_KS_PARITY_CHK_EN
    always_comb begin
        key_par_ok = 1'b1;
        if (KEY_W == 64) begin
            for (int b = 0; b < 8; b++) begin
                if (!(^key64[8*b +: 8])) key_par_ok = 1'b0;
            end
        end
    end
`else
    assign key_par_ok = 1'b1;
    assign key_par_err = 1'b0;
`endif

    // CD16 equals CD0, so decrypt starts from PC1 directly and walks backwards by right rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= KS_IDLE;
            cd        <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
`ifdef DES_KS_PARITY_CHK_EN
            key_par_err <= 1'b0;
`endif
        end else begin
`ifdef DES_KS_PARITY_CHK_EN
            key_par_err <= 1'b0;
`endif
            case (state)
                KS_IDLE: begin
                    if (key_valid && key_par_ok) begin
                        cd        <= decrypt ? cd_load : rotl_cd(cd_load, 2'd1);
                        cnt       <= '0;
                        mode      <= decrypt;
                        state     <= KS_GEN;
                        key_ready <= 1'b0;
                        rk_valid  <= 1'b1;
                        rk_last   <= 1'b0;
                    end
`ifdef DES_KS_PARITY_CHK_EN
                    else if (key_valid) begin
                        key_par_err <= 1'b1;
                    end
`endif
                end
                KS_GEN: begin
                    if (rk_ready) begin
                        if (cnt == 4'd15) begin
                            state     <= KS_IDLE;
                            cnt       <= '0;
                            key_ready <= 1'b1;
                            rk_valid  <= 1'b0;
                            rk_last   <= 1'b0;
                        end else begin
                            cd      <= mode ? rotr_cd(cd, SHIFT_TAB[4'd15 - cnt])
                                            : rotl_cd(cd, SHIFT_TAB[cnt + 4'd1]);
                            cnt     <= cnt + 4'd1;
                            rk_last <= (cnt == 4'd14);
                        end
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

    assign rk_round = cnt;
    assign busy     = (state != KS_IDLE);

    des_ks_pc2 u_pc2 (
        .cd (cd),
        .rk (rk_data)
    );

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Directed bench for des_key_schedule_seq using the classic 0x133457799BBCDFF1 schedule.
// Parity steps follow DES_KS_PARITY_CHK_EN when it is defined.
module tb_des_key_schedule_seq;

    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;

    localparam logic [47:0] EXP_KEYS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        decrypt;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] rk_data;
    logic [3:0]  rk_round;
    logic        rk_last;
    logic        busy;
    logic        key_par_err;

    int compared   = 0;
    int mismatched = 0;

    des_key_schedule_seq #(.KEY_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .decrypt     (decrypt),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .rk_last     (rk_last),
        .busy        (busy),
        .key_par_err (key_par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one key for a single cycle; the block accepts it at the next edge.
    task automatic applyStimulus(input logic [63:0] key, input logic dec);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic runKey(input string tag, input logic [63:0] key, input logic dec,
                          input logic [31:0] bp);
        int got    = 0;
        int cycles = 0;
        applyStimulus(key, dec);
        while (got < 16 && cycles < 200) begin
            rk_ready = bp[cycles % 32];
            checkOutput({tag, ".valid"}, 64'(rk_valid), 64'd1);
            checkOutput({tag, ".round"}, 64'(rk_round), 64'(got));
            checkOutput({tag, ".data"}, 64'(rk_data), 64'(dec ? EXP_KEYS[15-got] : EXP_KEYS[got]));
            checkOutput({tag, ".last"}, 64'(rk_last), 64'(got == 15));
            if (rk_ready) got++;
            step();
            cycles++;
        end
        checkOutput({tag, ".count"}, 64'(got), 64'd16);
        checkOutput({tag, ".end_valid"}, 64'(rk_valid), 64'd0);
        checkOutput({tag, ".end_ready"}, 64'(key_ready), 64'd1);
        checkOutput({tag, ".end_busy"}, 64'(busy), 64'd0);
        rk_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        rk_ready  = 1'b1;
        step();
        step();
        checkOutput("reset.key_ready", 64'(key_ready), 64'd1);
        checkOutput("reset.rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("reset.rk_round", 64'(rk_round), 64'd0);
        checkOutput("reset.rk_last", 64'(rk_last), 64'd0);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.rk_data", 64'(rk_data), 64'd0);
        checkOutput("reset.par_err", 64'(key_par_err), 64'd0);
        rst_n = 1'b1;
        step();

        runKey("enc", KEY_GOOD, 1'b0, 32'hFFFF_FFFF);
        step();
        runKey("dec", KEY_GOOD, 1'b1, 32'hFFFF_FFFF);
        step();
        runKey("enc_bp", KEY_GOOD, 1'b0, 32'hB4D2_6A39);
        step();
        runKey("dec_bp", KEY_GOOD, 1'b1, 32'h5A3C_96E1);
        step();

        // Abort mid-sequence with asynchronous reset, then reload.
        applyStimulus(KEY_GOOD, 1'b0);
        for (int i = 0; i < 7; i++) step();
        checkOutput("abort.round_before", 64'(rk_round), 64'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("abort.key_ready", 64'(key_ready), 64'd1);
        checkOutput("abort.rk_round", 64'(rk_round), 64'd0);
        checkOutput("abort.rk_data", 64'(rk_data), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        runKey("reload", KEY_GOOD, 1'b0, 32'hFFFF_FFFF);
        step();

        // key_valid held high: GEN ignores key_in/decrypt, one bubble before the next accept.
        key_in    = KEY_GOOD;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            checkOutput("hold.round", 64'(rk_round), 64'(i));
            checkOutput("hold.data", 64'(rk_data), 64'(EXP_KEYS[i]));
            if (i == 1) begin
                key_in  = '0;
                decrypt = 1'b1;
            end
            if (i == 15) begin
                key_in  = KEY_GOOD;
                decrypt = 1'b0;
            end
            step();
        end
        checkOutput("hold.bubble_ready", 64'(key_ready), 64'd1);
        checkOutput("hold.bubble_valid", 64'(rk_valid), 64'd0);
        step();
        checkOutput("hold.reaccept_valid", 64'(rk_valid), 64'd1);
        checkOutput("hold.reaccept_round", 64'(rk_round), 64'd0);
        checkOutput("hold.reaccept_data", 64'(rk_data), 64'(EXP_KEYS[0]));
        key_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();
        checkOutput("hold.drain_valid", 64'(rk_valid), 64'd0);
        step();

`ifdef DES_KS_PARITY_CHK_EN
        applyStimulus(KEY_BADP, 1'b0);
        checkOutput("par.err_pulse", 64'(key_par_err), 64'd1);
        checkOutput("par.no_valid", 64'(rk_valid), 64'd0);
        checkOutput("par.key_ready", 64'(key_ready), 64'd1);
        checkOutput("par.busy", 64'(busy), 64'd0);
        step();
        checkOutput("par.err_clear", 64'(key_par_err), 64'd0);
        checkOutput("par.still_idle", 64'(rk_valid), 64'd0);
        runKey("par_good", KEY_GOOD, 1'b0, 32'hFFFF_FFFF);
`else
        applyStimulus(KEY_BADP, 1'b0);
        checkOutput("nopar.err", 64'(key_par_err), 64'd0);
        checkOutput("nopar.loaded", 64'(rk_valid), 64'd1);
        checkOutput("nopar.data", 64'(rk_data), 64'(EXP_KEYS[0]));
        for (int i = 0; i < 16; i++) step();
        checkOutput("nopar.done", 64'(rk_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
